sram_arbiter: RTL

Two-port arbiter and sequencer that shares the single SRAM controller between the pipeline MEM stage (port 0) and a secondary master such as a program loader or DMA (port 1). It accepts read and write requests, grants one at a time, and drives the controller's enable, address and data inputs. It holds the enables stable until the controller reports completion, then returns read data with a one-cycle acknowledge. It also produces per-port stall signals for the pipeline freeze logic and aborts any access the controller never completes.

---
 rtl/sram_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between the pipeline MEM stage (port 0)
// and a secondary master (port 1). One access in flight at a time. Enables, address
// and write data are registered and held until the controller reports ready.
// Latency: grant 1 cycle after request; ack 1 cycle after completion (or watchdog abort).
// Backpressure: requests are levels held until ack; pN_stall freezes the requester.
// Ports: clk/rst (async, active-high); pN_rd/wr/addr/wdata in, pN_rdata/ack/stall out;
//        mem_read_en/write_en/address/write_data out, mem_read_data/ready in;
//        timeout_err out (sticky until rst).
// Option: define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 0
//         has fixed priority.
module sram_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_rd,
    input  logic        p0_wr,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ack,
    output logic        p0_stall,
    input  logic        p1_rd,
    input  logic        p1_wr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_ack,
    output logic        p1_stall,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready,
    output logic        timeout_err
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;     // 0 = port 0, 1 = port 1
    logic          op_wr_q, op_wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          rd_en_q, rd_en_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   p0_rdata_q, p0_rdata_d;
    logic [31:0]   p1_rdata_q, p1_rdata_d;
    logic          p0_ack_q, p0_ack_d;
    logic          p1_ack_q, p1_ack_d;
    logic          terr_q, terr_d;

    logic pend0, pend1, win1, done, abort;

    assign pend0 = p0_rd | p0_wr;
    assign pend1 = p1_rd | p1_wr;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // rr_q names the last granted port; the other port wins a tie.
    logic rr_q, rr_d;
    assign win1 = pend1 & (~pend0 | ~rr_q);
`else
    assign win1 = pend1 & ~pend0;
`endif

    // The first BUSY cycle (watchdog still 0) ignores mem_ready: the controller has
    // only just seen the enables and its ready may still reflect the idle state.
    assign done  = (state_q == S_BUSY) && mem_ready && (wdog_q != '0);
    assign abort = (state_q == S_BUSY) && (wdog_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wdog_d     = wdog_q;
        rd_en_d    = rd_en_q;
        wr_en_d    = wr_en_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        p0_ack_d   = 1'b0;
        p1_ack_d   = 1'b0;
        terr_d     = terr_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr_d       = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pend0 || pend1) begin
                    state_d = S_BUSY;
                    grant_d = win1;
                    // Write wins when a port raises rd and wr together.
                    op_wr_d = win1 ? p1_wr : p0_wr;
                    addr_d  = win1 ? p1_addr : p0_addr;
                    wdata_d = win1 ? p1_wdata : p0_wdata;
                    wdog_d  = '0;
                    rd_en_d = ~op_wr_d;
                    wr_en_d = op_wr_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    rr_d    = win1;
`endif
                end
            end
            default: begin
                if (done || abort) begin
                    if (done && !op_wr_q) begin
                        if (grant_q) p1_rdata_d = mem_read_data;
                        else         p0_rdata_d = mem_read_data;
                    end
                    if (!done) terr_d = 1'b1;
                    p0_ack_d = ~grant_q;
                    p1_ack_d = grant_q;
                    // Clearing the mem-side registers gives zero address/data in IDLE
                    // and guarantees at least one idle cycle between accesses.
                    state_d  = S_IDLE;
                    rd_en_d  = 1'b0;
                    wr_en_d  = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wdog_q     <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wdog_q     <= wdog_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            p0_ack_q   <= p0_ack_d;
            p1_ack_q   <= p1_ack_d;
            terr_q     <= terr_d;
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`endif

    assign mem_read_en    = rd_en_q;
    assign mem_write_en   = wr_en_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign p0_rdata       = p0_rdata_q;
    assign p1_rdata       = p1_rdata_q;
    assign p0_ack         = p0_ack_q;
    assign p1_ack         = p1_ack_q;
    assign timeout_err    = terr_q;
    assign p0_stall       = pend0 & ~p0_ack_q;
    assign p1_stall       = pend1 & ~p1_ack_q;

endmodule
